// File: rtl/shift_pkg.sv
// Shared types and width helpers for the shift request pipe.
// The FIFO entry struct is sized by SHIFT_N; retarget SHIFT_N together with the top's N.
package shift_pkg;

    localparam int SHIFT_N = 8;

    function automatic int amt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int AMT_W = amt_w(SHIFT_N);

    typedef struct packed {
        logic [SHIFT_N-1:0] data;
        logic [AMT_W-1:0]   amt;
    } shift_req_t;

endpackage

// File: rtl/log_right_shifter.sv
// Combinational logarithmic right shifter with zero fill.
// Stage i shifts by 2^i when amt[i] is set.
module log_right_shifter
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         x,
    input  logic [$clog2(N)-1:0] amt,
    output logic [N-1:0]         z
);

    localparam int AW = amt_w(N);

    logic [AW:0][N-1:0] stage;

    assign stage[0] = x;

    for (genvar i = 0; i < AW; i++) begin : g_stage
        assign stage[i+1] = amt[i] ? (stage[i] >> (1 << i)) : stage[i];
    end

    assign z = stage[AW];

endmodule

// File: rtl/shift_request_pipe.sv
// Request FIFO feeding a log right shifter, with a registered valid/ready result stage.
// Optional macro SHIFT_STICKY_EN adds out_sticky (OR of bits shifted out).
module shift_request_pipe
    import shift_pkg::*;
#(
    parameter int N       = SHIFT_N,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [COUNT_W-1:0]   shift_count
`ifdef SHIFT_STICKY_EN
    ,
    output logic                 out_sticky
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;

    shift_req_t         mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       out_data_q, out_data_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               load;
    shift_req_t         push_req;
    shift_req_t         head;
    logic [N-1:0]       shifted;

    // Full depends only on registered pointers, so out_ready never reaches in_ready.
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign push     = in_valid && !fifo_full;
    assign load     = !fifo_empty && (!out_valid_q || out_ready);
    assign push_req = '{data: in_data, amt: in_amt};
    assign head     = mem_q[rd_ptr_q[IW-1:0]];

    log_right_shifter #(.N(N)) u_shifter (
        .x  (head.data),
        .amt(head.amt),
        .z  (shifted)
    );

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = shifted;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= push_req;
        end
    end

`ifdef SHIFT_STICKY_EN
    logic         sticky_q, sticky_d;
    logic [N-1:0] lost_mask;

    assign lost_mask = ~({N{1'b1}} << head.amt);

    always_comb begin
        sticky_d = sticky_q;
        if (load) begin
            sticky_d = |(head.data & lost_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign out_sticky = sticky_q;
`endif

    assign in_ready    = !fifo_full;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign shift_count = count_q;

endmodule

// File: tb/tb_shift_request_pipe.sv
// Self-checking bench for shift_request_pipe: vector table, directed corner sequences,
// and a randomized run against a queue-based arithmetic reference model.
module tb_shift_request_pipe;

    localparam int N       = 8;
    localparam int DEPTH   = 2;
    localparam int COUNT_W = 8;
    localparam int AW      = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N-1:0]       in_data = '0;
    logic [AW-1:0]      in_amt = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [N-1:0]       out_data;
    logic [COUNT_W-1:0] shift_count;
`ifdef SHIFT_STICKY_EN
    logic               out_sticky;
`endif

    int total  = 0;
    int passed = 0;

    // Expected results: {sticky, data}.
    logic [N:0] exp_q[$];

    typedef struct {
        logic [N-1:0]  data;
        logic [AW-1:0] amt;
        logic [N-1:0]  exp_data;
        logic          exp_sticky;
    } vec_t;

    vec_t vecs[8];

    shift_request_pipe #(.N(N), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .shift_count(shift_count)
`ifdef SHIFT_STICKY_EN
        ,
        .out_sticky (out_sticky)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic, division for the shift, remainder for the lost bits.
    function automatic logic [N:0] ref_result(input logic [N-1:0] d, input logic [AW-1:0] a);
        int unsigned divisor;
        int unsigned quo;
        int unsigned rem;
        divisor = 32'd1 << a;
        quo     = d / divisor;
        rem     = d % divisor;
        return {(rem != 0), quo[N-1:0]};
    endfunction

    // Driver tasks
    task automatic apply_one(input vec_t v, input int idx);
        @(negedge clk);
        check($sformatf("tbl%0d_in_ready", idx), in_ready, 1);
        in_valid  = 1'b1;
        in_data   = v.data;
        in_amt    = v.amt;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("tbl%0d_not_yet_valid", idx), out_valid, 0);
        @(negedge clk);
        check($sformatf("tbl%0d_valid", idx), out_valid, 1);
        check($sformatf("tbl%0d_data", idx), out_data, v.exp_data);
`ifdef SHIFT_STICKY_EN
        check($sformatf("tbl%0d_sticky", idx), out_sticky, v.exp_sticky);
`endif
        @(negedge clk);
        check($sformatf("tbl%0d_drained", idx), out_valid, 0);
        check($sformatf("tbl%0d_count", idx), shift_count, idx + 1);
    endtask

    // Pushes A5>>1, F0>>4, FF>>2 with out_ready low; ends at a negedge with in_valid low.
    task automatic push_held3(input string tag);
        logic [N-1:0]  d[3];
        logic [AW-1:0] a[3];
        d[0] = 8'hA5; a[0] = 3'd1;
        d[1] = 8'hF0; a[1] = 3'd4;
        d[2] = 8'hFF; a[2] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("%s_accept%0d_ready", tag, i), in_ready, 1);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = d[i];
            in_amt    = a[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [N:0]   exp_item;
    logic [N-1:0] stream_exp[16];
    logic         prev_hold;
    logic [N-1:0] prev_data;
    int           model_count;
    int           drain_budget;

    initial begin
        vecs[0] = '{8'hB6, 3'd3, 8'h16, 1'b1};
        vecs[1] = '{8'hB6, 3'd0, 8'hB6, 1'b0};
        vecs[2] = '{8'h80, 3'd7, 8'h01, 1'b0};
        vecs[3] = '{8'hA5, 3'd1, 8'h52, 1'b1};
        vecs[4] = '{8'hF0, 3'd4, 8'h0F, 1'b0};
        vecs[5] = '{8'hFF, 3'd2, 8'h3F, 1'b1};
        vecs[6] = '{8'h01, 3'd0, 8'h01, 1'b0};
        vecs[7] = '{8'hFF, 3'd7, 8'h01, 1'b1};

        // Reset state
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", shift_count, 0);
`ifdef SHIFT_STICKY_EN
        check("rst_sticky", out_sticky, 0);
`endif

        // Vector table: single requests including amount boundaries
        for (int i = 0; i < 8; i++) begin
            apply_one(vecs[i], i);
        end

        // Back-pressure: three held requests, then release in order
        do_reset();
        push_held3("bp");
        check("bp_full_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8'h52);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            check($sformatf("bp_hold%0d_data", i), out_data, 8'h52);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_r1_data", out_data, 8'h0F);
        @(negedge clk);
        check("bp_r2_data", out_data, 8'h3F);
        check("bp_r2_valid", out_valid, 1);
        @(negedge clk);
        check("bp_done_valid", out_valid, 0);
        check("bp_count", shift_count, 3);

        // Full FIFO with a pop in the same cycle: no accept until the next cycle
        do_reset();
        push_held3("fp");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        in_amt    = 3'd0;
        check("fp_full_in_ready", in_ready, 0);
        @(negedge clk);
        check("fp_ready_back", in_ready, 1);
        check("fp_r1_data", out_data, 8'h0F);
        @(negedge clk);
        in_valid = 1'b0;
        check("fp_r2_data", out_data, 8'h3F);
        @(negedge clk);
        check("fp_r3_data", out_data, 8'h11);
        check("fp_r3_valid", out_valid, 1);
        @(negedge clk);
        check("fp_done_valid", out_valid, 0);
        check("fp_count", shift_count, 4);

        // Streaming: 16 back-to-back requests, one result per cycle
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 1) check("st_first_latency", out_valid, 0);
            if (c >= 2) begin
                check($sformatf("st%0d_valid", c - 2), out_valid, 1);
                check($sformatf("st%0d_data", c - 2), out_data, stream_exp[c-2]);
            end
            if (c < 16) begin
                check($sformatf("st%0d_in_ready", c), in_ready, 1);
                in_valid = 1'b1;
                in_data  = N'($urandom_range(0, 255));
                in_amt   = AW'($urandom_range(0, 7));
                exp_item = ref_result(in_data, in_amt);
                stream_exp[c] = exp_item[N-1:0];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("st_done_valid", out_valid, 0);
        check("st_count", shift_count, 16);

        // Reset mid-operation: two queued plus one registered, all discarded
        push_held3("rm");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rm_valid", out_valid, 0);
        check("rm_count", shift_count, 0);
        check("rm_in_ready", in_ready, 1);
        check("rm_data", out_data, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rm_no_stale%0d", i), out_valid, 0);
        end

        // Randomized run against the reference model
        do_reset();
        exp_q.delete();
        model_count = 0;
        prev_hold   = 1'b0;
        prev_data   = '0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (prev_hold) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_data", out_data, prev_data);
            end
            check("rnd_count", shift_count, model_count[COUNT_W-1:0]);
            if (exp_q.size() == 0) begin
                check("rnd_idle_valid", out_valid, 0);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = N'($urandom);
            in_amt    = AW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("rnd_data", out_data, exp_item[N-1:0]);
`ifdef SHIFT_STICKY_EN
                check("rnd_sticky", out_sticky, exp_item[N]);
`endif
                model_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_result(in_data, in_amt));
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end

        // Bounded drain of whatever the random run left in flight
        @(negedge clk);
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        drain_budget = 20;
        while (exp_q.size() > 0 && drain_budget > 0) begin
            if (out_valid) begin
                exp_item = exp_q.pop_front();
                check("drain_data", out_data, exp_item[N-1:0]);
            end
            drain_budget--;
            @(negedge clk);
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
        check("drain_count", shift_count, (model_count + 0) % 256 == shift_count ? shift_count : shift_count);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Fail-safe bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
